// File: rtl/uart_tx_unit_if.sv
// ============================================================================
// Module   : uart_tx_unit_if
// Brief    : Byte-push side of the UART transmitter (data, push, full, overflow)
// Revision : 1.0
// ============================================================================
`default_nettype none

interface uart_tx_unit_if;
    logic [7:0] tx_data;
    logic       tx_push;
    logic       tx_full;
    logic       tx_overflow;

    modport master (output tx_data, output tx_push, input  tx_full, input  tx_overflow);
    modport slave  (input  tx_data, input  tx_push, output tx_full, output tx_overflow);
endinterface

`default_nettype wire

// File: rtl/uart_tx_unit.sv
// ============================================================================
// Module   : uart_tx_unit
// Brief    : UART 8N1 transmitter (LSB first) fed by a small byte FIFO
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_unit #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DEPTH        = 4
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_unit_if.slave bus,
    output logic          tx,
    output logic          tx_busy,
    output logic          tx_done_tick
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_BW = $clog2(CLKS_PER_BIT);
    localparam logic [c_BW-1:0] c_BAUD_LAST = c_BW'(CLKS_PER_BIT - 1);
    localparam logic [c_AW:0]   c_DEPTH     = (c_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            r_overflow;

    state_t          r_state;
    logic [c_BW-1:0] r_baud;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_tx;

    state_t          w_state_nx;
    logic [c_BW-1:0] w_baud_nx;
    logic [2:0]      w_bit_nx;
    logic [7:0]      w_shift_nx;
    logic            w_tx_nx;
    logic            w_pop;
    logic            w_done;

    logic w_full;
    logic w_empty;
    logic w_push_ok;
    logic w_baud_last;

    assign w_full      = (r_count == c_DEPTH);
    assign w_empty     = (r_count == '0);
    // Fullness is judged on the registered count, so a same-cycle pop never rescues a push.
    assign w_push_ok   = bus.tx_push && !w_full;
    assign w_baud_last = (r_baud == c_BAUD_LAST);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= bus.tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + c_AW'(1);
            if (w_push_ok && !w_pop)      r_count <= r_count + (c_AW + 1)'(1);
            else if (!w_push_ok && w_pop) r_count <= r_count - (c_AW + 1)'(1);
            if (bus.tx_push && w_full) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nx;
            r_baud    <= w_baud_nx;
            r_bit_idx <= w_bit_nx;
            r_shift   <= w_shift_nx;
            r_tx      <= w_tx_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_baud_nx  = r_baud + c_BW'(1);
        w_bit_nx   = r_bit_idx;
        w_shift_nx = r_shift;
        w_tx_nx    = r_tx;
        w_pop      = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_baud_nx = '0;
                w_tx_nx   = 1'b1;
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_shift_nx = r_mem[r_rd_ptr];
                    w_tx_nx    = 1'b0;
                    w_state_nx = S_START;
                end
            end
            S_START: begin
                if (w_baud_last) begin
                    w_baud_nx  = '0;
                    w_bit_nx   = '0;
                    w_tx_nx    = r_shift[0];
                    w_state_nx = S_DATA;
                end
            end
            S_DATA: begin
                if (w_baud_last) begin
                    w_baud_nx = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_tx_nx    = 1'b1;
                        w_state_nx = S_STOP;
                    end else begin
                        w_shift_nx = {1'b0, r_shift[7:1]};
                        w_tx_nx    = r_shift[1];
                        w_bit_nx   = r_bit_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (w_baud_last) begin
                    w_done    = 1'b1;
                    w_baud_nx = '0;
                    // Chain straight into the next start bit when more bytes wait.
                    if (!w_empty) begin
                        w_pop      = 1'b1;
                        w_shift_nx = r_mem[r_rd_ptr];
                        w_tx_nx    = 1'b0;
                        w_state_nx = S_START;
                    end else begin
                        w_tx_nx    = 1'b1;
                        w_state_nx = S_IDLE;
                    end
                end
            end
            default: begin
                w_baud_nx  = '0;
                w_tx_nx    = 1'b1;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign tx              = r_tx;
    assign tx_busy         = (r_state != S_IDLE) || !w_empty;
    assign tx_done_tick    = w_done && !reset;
    assign bus.tx_full     = w_full;
    assign bus.tx_overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_unit.sv
// ============================================================================
// Module   : tb_uart_tx_unit
// Brief    : Scoreboard bench: timing-level byte model feeds a serial-line monitor
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_unit;
    localparam int CA = 4;
    localparam int DA = 4;
    localparam int CB = 2;
    localparam int FRAME = 10 * CA;
    localparam int CYC_LIMIT = 30000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_tx_unit_if a_if ();
    uart_tx_unit_if b_if ();
    logic a_tx, a_busy, a_done;
    logic b_tx, b_busy, b_done;

    uart_tx_unit #(.CLKS_PER_BIT(CA), .DEPTH(DA)) u_dut_a (
        .clk(clk), .reset(reset), .bus(a_if),
        .tx(a_tx), .tx_busy(a_busy), .tx_done_tick(a_done));

    uart_tx_unit #(.CLKS_PER_BIT(CB), .DEPTH(DA)) u_dut_b (
        .clk(clk), .reset(reset), .bus(b_if),
        .tx(b_tx), .tx_busy(b_busy), .tx_done_tick(b_done));

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int frames = 0;
    int n_acc = 0;

    // Model: each accepted byte's pop edge; a byte leaves the FIFO at its pop edge.
    int         q_pop[$];
    logic [7:0] sb_data[$];
    int         sb_edge[$];
    int         last_pop = -1000000;
    bit         m_ovf = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic int model_count(input int now);
        int n = 0;
        foreach (q_pop[i]) if (q_pop[i] > now) n++;
        return n;
    endfunction

    function automatic bit model_busy(input int now);
        return (model_count(now) > 0) || (now >= last_pop && now < last_pop + FRAME);
    endfunction

    function automatic void model_push(input logic [7:0] b, input int e);
        int occ = 0;
        int p;
        foreach (q_pop[i]) if (q_pop[i] >= e) occ++;
        if (occ < DA) begin
            p = (e + 1 > last_pop + FRAME) ? e + 1 : last_pop + FRAME;
            last_pop = p;
            q_pop.push_back(p);
            sb_data.push_back(b);
            sb_edge.push_back(p);
            n_acc++;
        end else begin
            m_ovf = 1'b1;
        end
    endfunction

    function automatic void model_reset();
        q_pop.delete();
        sb_data.delete();
        sb_edge.delete();
        last_pop = -1000000;
        m_ovf = 1'b0;
        n_acc = frames;
    endfunction

    // Monitor: reassembles frames on DUT A's line and scores them against the queue.
    bit         m_active = 1'b0;
    bit         m_rst;
    int         m_j, m_bad, m_bitn, m_idx;
    logic [7:0] m_exp, m_rx;
    logic       m_expv;

    always begin
        @(posedge clk);
        cyc++;
        m_rst = reset;
        #1;
        if (cyc > CYC_LIMIT) begin
            $display("FAIL timeout: cycle %0d reached limit %0d", cyc, CYC_LIMIT);
            $fatal(1);
        end
        if (m_rst) begin
            m_active = 1'b0;
        end else begin
            if (!m_active) begin
                if (a_done !== 1'b0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL idle_done: got %b expected 0 (cycle %0d)", a_done, cyc);
                end
                if (a_tx === 1'b0) begin
                    m_active = 1'b1;
                    m_j = 0;
                    m_bad = 0;
                    m_rx = 8'h00;
                    if (sb_data.size() == 0) begin
                        vectors++;
                        miscompares++;
                        m_exp = 8'h00;
                        $display("FAIL unexpected_frame: got start at %0d expected none", cyc);
                    end else begin
                        m_exp = sb_data.pop_front();
                        check("frame_start", cyc, sb_edge.pop_front());
                    end
                end
            end
            if (m_active) begin
                m_bitn = m_j / CA;
                m_idx = (m_bitn >= 1 && m_bitn <= 8) ? m_bitn - 1 : 0;
                m_expv = (m_bitn == 0) ? 1'b0 : (m_bitn == 9) ? 1'b1 : m_exp[m_idx];
                if (a_tx !== m_expv) m_bad++;
                if (m_bitn >= 1 && m_bitn <= 8 && (m_j % CA) == CA / 2) m_rx[m_idx] = a_tx;
                if (m_j == FRAME - 1) begin
                    vectors++;
                    if (m_bad != 0 || a_done !== 1'b1) begin
                        miscompares++;
                        $display("FAIL frame: got byte %02h (%0d bad cycles, done=%b) expected byte %02h", m_rx, m_bad, a_done, m_exp);
                    end
                    frames++;
                    m_active = 1'b0;
                end else if (a_done !== 1'b0) begin
                    m_bad++;
                end
                m_j++;
            end
        end
    end

    task automatic do_push(input logic [7:0] b);
        @(negedge clk);
        a_if.tx_data = b;
        a_if.tx_push = 1'b1;
        model_push(b, cyc + 1);
    endtask

    task automatic release_push();
        @(negedge clk);
        a_if.tx_push = 1'b0;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_full"}, a_if.tx_full, (model_count(cyc) == DA));
        check({tag, "_busy"}, a_busy, model_busy(cyc));
        check({tag, "_ovf"}, a_if.tx_overflow, m_ovf);
    endtask

    task automatic drain(input string tag);
        while (model_busy(cyc)) @(negedge clk);
        repeat (2) @(negedge clk);
        check({tag, "_drain"}, sb_data.size(), 0);
        check({tag, "_frames"}, frames, n_acc);
        check({tag, "_tx_idle"}, a_tx, 1'b1);
        check_status(tag);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic boundary_b();
        logic [21:0] g_tx, e_tx, g_done, e_done, g_busy, e_busy;
        logic [7:0]  bb;
        int          j;
        bb = 8'h81;
        @(negedge clk);
        b_if.tx_data = bb;
        b_if.tx_push = 1'b1;
        for (int k = 0; k < 22; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) b_if.tx_push = 1'b0;
            j = k - 1;
            g_tx[k] = b_tx;
            g_done[k] = b_done;
            g_busy[k] = b_busy;
            if (j < 0 || j >= 10 * CB) e_tx[k] = 1'b1;
            else if (j / CB == 0)      e_tx[k] = 1'b0;
            else if (j / CB == 9)      e_tx[k] = 1'b1;
            else                       e_tx[k] = bb[j / CB - 1];
            e_done[k] = (j == 10 * CB - 1);
            e_busy[k] = (j < 10 * CB);
        end
        check("b_tx_wave", g_tx, e_tx);
        check("b_done_wave", g_done, e_done);
        check("b_busy_wave", g_busy, e_busy);
    endtask

    int p0;
    int gap;

    initial begin
        a_if.tx_data = 8'h00;
        a_if.tx_push = 1'b0;
        b_if.tx_data = 8'h00;
        b_if.tx_push = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_tx", a_tx, 1'b1);
        check("rst_done", a_done, 1'b0);
        check_status("rst");
        check("rst_b", {b_tx, b_busy, b_done, b_if.tx_full, b_if.tx_overflow}, 5'b10000);

        do_push(8'hA5);
        release_push();
        drain("single");

        do_push(8'h00);
        do_push(8'hFF);
        do_push(8'h3C);
        release_push();
        drain("b2b");

        for (int i = 0; i < 6; i++) do_push(8'h10 + 8'(i));
        release_push();
        check_status("ovf_burst");
        drain("ovf");

        reset_pulse();
        check_status("rst2");

        // Full FIFO, then a push landing on the STOP->START pop edge.
        do_push(8'h55);
        p0 = last_pop;
        release_push();
        while (cyc < p0 + 2) @(negedge clk);
        for (int i = 0; i < DA; i++) do_push(8'($urandom));
        release_push();
        check_status("fill");
        while (cyc < p0 + FRAME - 2) @(negedge clk);
        do_push(8'hEE);
        release_push();
        check_status("pop_push");
        drain("pop_push");

        // Abort during data bit 3 with two bytes still queued.
        reset_pulse();
        do_push(8'h96);
        p0 = last_pop;
        do_push(8'h5A);
        do_push(8'hC3);
        release_push();
        while (cyc < p0 + 4 * CA + 1) @(negedge clk);
        reset_pulse();
        check("abort_tx", a_tx, 1'b1);
        check("abort_done", a_done, 1'b0);
        check_status("abort");
        repeat (100) @(negedge clk);
        drain("abort");

        for (int n = 0; n < 30; n++) begin
            do_push(8'($urandom));
            gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 45));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                a_if.tx_push = 1'b0;
            end
            if (gap > 0) check_status("rand");
        end
        release_push();
        drain("rand");

        boundary_b();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
